tf_response_classify: RTL and testbench

Downstream consumer of the learned transfer-function spectrum. After the learning stage signals completion, the block scans the real and imaginary spectrum RAMs through their clk_50m read ports. It computes per-bin power, finds the peak and the −3 dB passband edges, and classifies the filter as low-pass, high-pass, band-pass or band-stop. Results drive the LEDs and seven-segment display logic.

---
 rtl/tf_response_classify.sv | 242 ++++++++++++++++++++++++
 tb/tb_tf_response_classify.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tf_response_classify.sv
`default_nettype none
// ============================================================================
// Module   : tf_response_classify
// Purpose  : Scans the learned transfer-function spectrum RAMs twice after
//            learning completes. The first pass finds the peak-power bin; the
//            second finds the -3 dB passband edges. The filter is classified
//            as none / LPF / HPF / BPF / BSF for the LED and 7-segment logic.
// Revision : 1.0  initial release
// ============================================================================
module tf_response_classify #(
  parameter int DEPTH = 2800,
  parameter int AW    = 12
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 learn_done,
  input  logic signed [15:0]   rd_real,
  input  logic signed [15:0]   rd_imag,
  output logic [AW-1:0]        real_addr,
  output logic [AW-1:0]        imag_addr,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           filter_type,
  output logic [AW-1:0]        peak_addr,
  output logic [31:0]          peak_pow,
  output logic [AW-1:0]        fc_lo,
  output logic [AW-1:0]        fc_hi
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_LPF  = 3'd1;
  localparam logic [2:0] TYPE_HPF  = 3'd2;
  localparam logic [2:0] TYPE_BPF  = 3'd3;
  localparam logic [2:0] TYPE_BSF  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_F1   = 3'd2,
    S_P2   = 3'd3,
    S_F2   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            flush_q, flush_d;
  logic            ld_prev_q;

  // Read-data pipeline tags: describe the bin whose data is on rd_* now.
  logic            dv_q;
  logic            dp2_q;
  logic [AW-1:0]   dbin_q;

  // Pass-1 running peak
  logic [31:0]     run_max_q;
  logic [AW-1:0]   run_paddr_q;

  // Pass-2 edge tracking
  logic [31:0]     thr_q;
  logic            pass0_q, passn_q, stop_q, found_q;
  logic [AW-1:0]   lo_q, hi_q;

  // Registered outputs
  logic            busy_q, done_q;
  logic [2:0]      type_q;
  logic [AW-1:0]   paddr_q, fclo_q, fchi_q;
  logic [31:0]     ppow_q;

  logic            w_rise, w_fall, w_start, w_p2_entry, w_pass;
  logic signed [31:0] w_sq_re, w_sq_im;
  logic [31:0]     w_pow;
  logic [2:0]      w_class;

  assign w_rise     = learn_done & ~ld_prev_q;
  assign w_fall     = ~learn_done & ld_prev_q;
  assign w_start    = (state_q == S_IDLE) && w_rise;
  assign w_p2_entry = (state_q == S_F1) && flush_q;

  // Each square is at most 2^30, so the unsigned sum never exceeds 2^31.
  assign w_sq_re = rd_real * rd_real;
  assign w_sq_im = rd_imag * rd_imag;
  assign w_pow   = $unsigned(w_sq_re) + $unsigned(w_sq_im);
  assign w_pass  = (w_pow >= thr_q);

  assign real_addr   = addr_q;
  assign imag_addr   = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign filter_type = type_q;
  assign peak_addr   = paddr_q;
  assign peak_pow    = ppow_q;
  assign fc_lo       = fclo_q;
  assign fc_hi       = fchi_q;

  // State, address and flush-counter registers
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
    end
  end

  // Next-state, address sequencing and two-cycle flush counting
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    flush_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (w_rise) begin
          state_d = S_P1;
          addr_d  = '0;
        end
      end
      S_P1: begin
        if (addr_q == LAST_ADDR) state_d = S_F1;
        else                     addr_d  = addr_q + AW'(1);
      end
      S_F1: begin
        flush_d = ~flush_q;
        if (flush_q) begin
          state_d = S_P2;
          addr_d  = '0;
        end
      end
      S_P2: begin
        if (addr_q == LAST_ADDR) state_d = S_F2;
        else                     addr_d  = addr_q + AW'(1);
      end
      S_F2: begin
        flush_d = ~flush_q;
        if (flush_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Classification from the recorded band-edge flags
  always_comb begin
    w_class = TYPE_NONE;
    if (run_max_q != 32'd0) begin
      unique case ({pass0_q, passn_q})
        2'b10:   w_class = TYPE_LPF;
        2'b01:   w_class = TYPE_HPF;
        2'b00:   w_class = TYPE_BPF;
        default: w_class = stop_q ? TYPE_BSF : TYPE_NONE;
      endcase
    end
  end

  // Datapath: learn_done history, read pipeline tags, peak and edge search
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      ld_prev_q   <= 1'b0;
      dv_q        <= 1'b0;
      dp2_q       <= 1'b0;
      dbin_q      <= '0;
      run_max_q   <= '0;
      run_paddr_q <= '0;
      thr_q       <= '0;
      pass0_q     <= 1'b0;
      passn_q     <= 1'b0;
      stop_q      <= 1'b0;
      found_q     <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
    end else begin
      ld_prev_q <= learn_done;
      dv_q      <= (state_q == S_P1) || (state_q == S_P2);
      dp2_q     <= (state_q == S_P2);
      dbin_q    <= addr_q;

      if (w_start) begin
        run_max_q   <= '0;
        run_paddr_q <= '0;
      end else if (dv_q && !dp2_q && (w_pow > run_max_q)) begin
        // Strict compare keeps the lowest address on ties.
        run_max_q   <= w_pow;
        run_paddr_q <= dbin_q;
      end

      if (w_p2_entry) begin
        thr_q   <= run_max_q >> 1;
        pass0_q <= 1'b0;
        passn_q <= 1'b0;
        stop_q  <= 1'b0;
        found_q <= 1'b0;
        lo_q    <= '0;
        hi_q    <= '0;
      end else if (dv_q && dp2_q) begin
        if (dbin_q == '0)        pass0_q <= w_pass;
        if (dbin_q == LAST_ADDR) passn_q <= w_pass;
        if (w_pass) begin
          hi_q <= dbin_q;
          if (!found_q) begin
            found_q <= 1'b1;
            lo_q    <= dbin_q;
          end
        end else begin
          stop_q <= 1'b1;
        end
      end
    end
  end

  // Status flags and result outputs; results change only when a scan ends
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      type_q  <= '0;
      paddr_q <= '0;
      ppow_q  <= '0;
      fclo_q  <= '0;
      fchi_q  <= '0;
    end else if (w_start) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
      type_q  <= w_class;
      paddr_q <= run_paddr_q;
      ppow_q  <= run_max_q;
      fclo_q  <= (run_max_q == 32'd0) ? '0 : lo_q;
      fchi_q  <= (run_max_q == 32'd0) ? '0 : hi_q;
    end else if (w_fall) begin
      done_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tf_response_classify.sv
`default_nettype none
// ============================================================================
// Module   : tb_tf_response_classify
// Purpose  : Self-checking bench for tf_response_classify. Spectrum RAMs are
//            modelled as arrays with one-cycle registered reads; expected
//            results come from a direct arithmetic model over the arrays.
// Revision : 1.0  initial release
// ============================================================================
module tb_tf_response_classify;

  localparam int DEPTH = 2800;
  localparam int AW    = 12;
  localparam int TDONE = 2 * DEPTH + 5;

  logic                clk_50m = 1'b0;
  logic                rst_n   = 1'b0;
  logic                learn_done = 1'b0;
  logic signed [15:0]  rd_real = '0;
  logic signed [15:0]  rd_imag = '0;
  logic [AW-1:0]       real_addr, imag_addr, peak_addr, fc_lo, fc_hi;
  logic                busy, done;
  logic [2:0]          filter_type;
  logic [31:0]         peak_pow;

  tf_response_classify #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .learn_done  (learn_done),
    .rd_real     (rd_real),
    .rd_imag     (rd_imag),
    .real_addr   (real_addr),
    .imag_addr   (imag_addr),
    .busy        (busy),
    .done        (done),
    .filter_type (filter_type),
    .peak_addr   (peak_addr),
    .peak_pow    (peak_pow),
    .fc_lo       (fc_lo),
    .fc_hi       (fc_hi)
  );

  always #10 clk_50m = ~clk_50m;

  logic signed [15:0] re_mem [DEPTH];
  logic signed [15:0] im_mem [DEPTH];

  // Spectrum RAMs: data for an address appears after the next rising edge
  always @(posedge clk_50m) begin
    rd_real <= (int'(real_addr) < DEPTH) ? re_mem[real_addr] : 16'sd0;
    rd_imag <= (int'(imag_addr) < DEPTH) ? im_mem[imag_addr] : 16'sd0;
  end

  int checks = 0;
  int errors = 0;

  // Model results for the current array contents
  longint m_type, m_paddr, m_ppow, m_lo, m_hi;
  // Result values the DUT must hold while a scan runs
  longint h_type = 0, h_paddr = 0, h_ppow = 0, h_lo = 0, h_hi = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void run_model();
    longint mx = 0, p, thr;
    int pa = 0, lo = -1, hi = -1;
    bit p0 = 0, pn = 0, stop = 0, pass;
    for (int i = 0; i < DEPTH; i++) begin
      p = longint'(re_mem[i]) * re_mem[i] + longint'(im_mem[i]) * im_mem[i];
      if (p > mx) begin mx = p; pa = i; end
    end
    thr = mx / 2;
    for (int i = 0; i < DEPTH; i++) begin
      p = longint'(re_mem[i]) * re_mem[i] + longint'(im_mem[i]) * im_mem[i];
      pass = (p >= thr);
      if (i == 0) p0 = pass;
      if (i == DEPTH - 1) pn = pass;
      if (pass) begin
        if (lo < 0) lo = i;
        hi = i;
      end else stop = 1;
    end
    m_ppow = mx; m_paddr = pa;
    if (mx == 0) begin
      m_type = 0; m_lo = 0; m_hi = 0;
    end else begin
      m_lo = lo; m_hi = hi;
      if (p0 && !pn)       m_type = 1;
      else if (!p0 && pn)  m_type = 2;
      else if (!p0 && !pn) m_type = 3;
      else if (stop)       m_type = 4;
      else                 m_type = 0;
    end
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"},  longint'(real_addr), 0);
    chk({tag, "_iaddr"}, longint'(imag_addr), 0);
    chk({tag, "_busy"},  longint'(busy), 0);
    chk({tag, "_done"},  longint'(done), 0);
    chk({tag, "_type"},  longint'(filter_type), 0);
    chk({tag, "_paddr"}, longint'(peak_addr), 0);
    chk({tag, "_ppow"},  longint'(peak_pow), 0);
    chk({tag, "_fclo"},  longint'(fc_lo), 0);
    chk({tag, "_fchi"},  longint'(fc_hi), 0);
  endtask

  function automatic longint exp_addr(input int n);
    if (n < DEPTH)              return n;
    else if (n < DEPTH + 2)     return DEPTH - 1;
    else if (n < 2 * DEPTH + 2) return n - DEPTH - 2;
    else                        return -1;
  endfunction

  // One scan: raise learn_done, then check every cycle up to completion.
  // glitch_at: cycle of a fall/rise pulse on learn_done while busy (-1 none).
  // rst_at: cycle at which reset is asserted (-1 none).
  task automatic scan(input string tag, input int glitch_at, input int rst_at);
    int  addr_err = 0, ctl_err = 0, hold_err = 0;
    bit  finished = 0;
    longint ea;
    run_model();
    @(negedge clk_50m); learn_done = 1'b0;
    @(negedge clk_50m); learn_done = 1'b1;
    for (int n = 0; n <= TDONE; n++) begin
      @(posedge clk_50m); #1;
      if (n == rst_at) begin
        rst_n = 1'b0;
        learn_done = 1'b0;
        #1;
        chk_zero_outputs({tag, "_midrst"});
        h_type = 0; h_paddr = 0; h_ppow = 0; h_lo = 0; h_hi = 0;
        return;
      end
      if (n == glitch_at)     learn_done = 1'b0;
      if (n == glitch_at + 1) learn_done = 1'b1;
      ea = exp_addr(n);
      if (ea >= 0 && longint'(real_addr) != ea) addr_err++;
      if (imag_addr != real_addr) addr_err++;
      if (n < TDONE) begin
        if (busy !== 1'b1 || done !== 1'b0) ctl_err++;
        if (longint'(filter_type) != h_type || longint'(peak_addr) != h_paddr ||
            longint'(peak_pow) != h_ppow || longint'(fc_lo) != h_lo ||
            longint'(fc_hi) != h_hi) hold_err++;
      end else begin
        finished = 1;
        chk({tag, "_busy_end"}, longint'(busy), 0);
        chk({tag, "_done_end"}, longint'(done), 1);
        chk({tag, "_type"},     longint'(filter_type), m_type);
        chk({tag, "_paddr"},    longint'(peak_addr), m_paddr);
        chk({tag, "_ppow"},     longint'(peak_pow), m_ppow);
        chk({tag, "_fclo"},     longint'(fc_lo), m_lo);
        chk({tag, "_fchi"},     longint'(fc_hi), m_hi);
      end
    end
    chk({tag, "_addr_seq_errs"}, addr_err, 0);
    chk({tag, "_busy_done_errs"}, ctl_err, 0);
    chk({tag, "_result_hold_errs"}, hold_err, 0);
    chk({tag, "_finished"}, finished, 1);
    h_type = m_type; h_paddr = m_paddr; h_ppow = m_ppow; h_lo = m_lo; h_hi = m_hi;
  endtask

  task automatic fill(input int re_in, input int lo, input int hi, input int re_out);
    for (int i = 0; i < DEPTH; i++) begin
      re_mem[i] = (i >= lo && i <= hi) ? 16'(re_in) : 16'(re_out);
      im_mem[i] = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin re_mem[i] = '0; im_mem[i] = '0; end
    repeat (3) @(posedge clk_50m);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk_50m); rst_n = 1'b1;

    // LPF: 30^2+10^2 = 1000 in bins 0..699, 3^2+1^2 = 10 elsewhere
    for (int i = 0; i < DEPTH; i++) begin
      re_mem[i] = (i < 700) ? 16'sd30 : 16'sd3;
      im_mem[i] = (i < 700) ? 16'sd10 : 16'sd1;
    end
    scan("lpf", -1, -1);
    chk("lpf_lit_type", longint'(filter_type), 1);
    chk("lpf_lit_fclo", longint'(fc_lo), 0);
    chk("lpf_lit_fchi", longint'(fc_hi), 699);
    chk("lpf_lit_paddr", longint'(peak_addr), 0);
    chk("lpf_lit_ppow", longint'(peak_pow), 1000);

    // done persists while learn_done stays high, then clears on its fall
    repeat (3) @(posedge clk_50m);
    #1 chk("done_persist", longint'(done), 1);
    @(negedge clk_50m); learn_done = 1'b0;
    @(posedge clk_50m); #1;
    chk("done_cleared", longint'(done), 0);
    chk("fall_keeps_type", longint'(filter_type), 1);
    chk("fall_keeps_fchi", longint'(fc_hi), 699);

    // BPF: 40000 shoulder sits below the 45000 threshold, so only the
    // 90000 spike at bin 1100 passes.
    fill(200, 1000, 1199, 1);
    re_mem[1100] = 16'sd300;
    scan("bpf", -1, -1);
    chk("bpf_lit_type", longint'(filter_type), 3);
    chk("bpf_lit_paddr", longint'(peak_addr), 1100);
    chk("bpf_lit_ppow", longint'(peak_pow), 90000);
    chk("bpf_lit_fclo", longint'(fc_lo), 1100);
    chk("bpf_lit_fchi", longint'(fc_hi), 1100);

    // HPF: pass only 2000..2799
    fill(100, 2000, DEPTH - 1, 1);
    scan("hpf", -1, -1);
    chk("hpf_lit_type", longint'(filter_type), 2);
    chk("hpf_lit_fclo", longint'(fc_lo), 2000);
    chk("hpf_lit_fchi", longint'(fc_hi), 2799);

    // BSF: notch at 1300..1399, second learn_done edge at cycle 100 ignored
    fill(1, 1300, 1399, 100);
    scan("bsf_glitch", 100, -1);
    chk("bsf_lit_type", longint'(filter_type), 4);
    chk("bsf_lit_paddr", longint'(peak_addr), 0);

    // All bins at -32768: maximum power, tie resolves to bin 0, flat -> 0
    for (int i = 0; i < DEPTH; i++) begin re_mem[i] = 16'h8000; im_mem[i] = 16'h8000; end
    scan("extreme", -1, -1);
    chk("ext_lit_ppow", longint'(peak_pow), 64'h8000_0000);
    chk("ext_lit_paddr", longint'(peak_addr), 0);
    chk("ext_lit_type", longint'(filter_type), 0);

    // All zero: no response
    fill(0, 0, 0, 0);
    scan("zero", -1, -1);
    chk("zero_lit_type", longint'(filter_type), 0);
    chk("zero_lit_fchi", longint'(fc_hi), 0);

    // Reset mid-scan, then a fresh scan with full latency
    fill(100, 0, 499, 2);
    scan("rst", -1, 3000);
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    @(posedge clk_50m); #1;
    chk_zero_outputs("post_rst");
    scan("after_rst", -1, -1);

    // Randomized band shapes
    for (int r = 0; r < 2; r++) begin
      int lo, hi, inv;
      lo  = $urandom_range(0, DEPTH - 1);
      hi  = $urandom_range(lo, DEPTH - 1);
      inv = $urandom_range(0, 1);
      for (int i = 0; i < DEPTH; i++) begin
        bit inband;
        inband = (i >= lo && i <= hi) ^ inv[0];
        if (inband) begin
          re_mem[i] = 16'(int'($urandom_range(1500, 2000)) * (($urandom_range(0, 1) != 0) ? 1 : -1));
          im_mem[i] = 16'(int'($urandom_range(0, 800)));
        end else begin
          re_mem[i] = 16'(int'($urandom_range(0, 40)) - 20);
          im_mem[i] = 16'(int'($urandom_range(0, 40)) - 20);
        end
      end
      scan($sformatf("rand%0d", r), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
